// File: rtl/prng_prefetch_buffer.sv
// Prefetch FIFO between a one-word-per-request PRNG and its consumer.
// Optional feature macro: PRNG_BUF_RANGE_EN (multiply-high range reduction of the head word).
module prng_prefetch_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        next_o,
    input  logic [31:0] rnd_i,
    input  logic        gen_write_i,
    output logic        rd_valid_o,
    input  logic        rd_ready_i,
    output logic [31:0] rd_data_o,
    input  logic [15:0] bound_i,
    output logic [4:0]  level_o,
    output logic [15:0] starve_o
);
    // Handshake: a word moves to the consumer on any edge where rd_valid_o && rd_ready_i.
    localparam int         PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_L = 5'(DEPTH);

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [4:0]       level;
    logic             in_flight;
    logic             capture;
    logic             pop;
    logic [31:0]      head;

    // Count the word already requested so the FIFO can never be over-asked.
    assign next_o     = rst_n && !gen_write_i && ((level + {4'd0, in_flight}) < DEPTH_L);
    assign capture    = in_flight && !gen_write_i && (level != DEPTH_L);
    assign rd_valid_o = (level != 5'd0);
    assign pop        = rd_valid_o && rd_ready_i && !gen_write_i;
    assign head       = mem[rd_ptr];
    assign level_o    = level;

    always_ff @(posedge clk) begin
        if (!rst_n || gen_write_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= 5'd0;
            in_flight <= 1'b0;
        end else begin
            in_flight <= next_o;
            if (capture) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({capture, pop})
                2'b10:   level <= level + 5'd1;
                2'b01:   level <= level - 5'd1;
                default: level <= level;
            endcase
        end
    end

    // Storage is never cleared; emptiness is tracked by level alone.
    always_ff @(posedge clk) begin
        if (rst_n && capture) begin
            mem[wr_ptr] <= rnd_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_o <= 16'd0;
        end else if (rd_ready_i && !rd_valid_o && (starve_o != 16'hFFFF)) begin
            starve_o <= starve_o + 16'd1;
        end
    end

`ifdef PRNG_BUF_RANGE_EN
    logic [47:0] product;
    assign product   = {16'h0, head} * {32'h0, bound_i};
    assign rd_data_o = (bound_i != 16'd0) ? {16'h0, product[47:32]} : head;
`else
    logic unused_bound;
    assign unused_bound = ^bound_i;
    assign rd_data_o    = head;
`endif

endmodule

// File: tb/tb_prng_prefetch_buffer.sv
// Bench for prng_prefetch_buffer: stub generator, queue-based reference model,
// per-cycle comparison plus directed literal checks.
module tb_prng_prefetch_buffer;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        next_o;
    logic [31:0] rnd;
    logic        gen_write;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic [15:0] bound;
    logic [4:0]  level;
    logic [15:0] starve;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 0;

    logic [31:0] seed_base;
    logic [31:0] gen_cnt;

    logic [31:0] model_q[$];
    int          m_pending;
    logic [31:0] m_pend_word;
    logic [31:0] m_cnt;
    logic [15:0] m_starve;

    prng_prefetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .next_o     (next_o),
        .rnd_i      (rnd),
        .gen_write_i(gen_write),
        .rd_valid_o (rd_valid),
        .rd_ready_i (rd_ready),
        .rd_data_o  (rd_data),
        .bound_i    (bound),
        .level_o    (level),
        .starve_o   (starve)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] exp_data(input logic [31:0] w, input logic [15:0] b);
`ifdef PRNG_BUF_RANGE_EN
        logic [63:0] p;
        if (b == 16'd0) return w;
        p = {32'h0, w} * {48'h0, b};
        return {16'h0, p[47:32]};
`else
        return w;
`endif
    endfunction

    function automatic logic exp_next_f();
        return rst_n && !gen_write && ((model_q.size() + m_pending) < DEPTH);
    endfunction

    // Stub generator: word = base + number of requests since its own reset/reseed.
    always @(posedge clk) begin
        if (!rst_n || gen_write) begin
            gen_cnt <= 32'd0;
        end else if (next_o) begin
            gen_cnt <= gen_cnt + 32'd1;
            rnd     <= seed_base + gen_cnt + 32'd1;
        end
    end

    // Reference model: a queue of words, plus one outstanding request.
    always @(posedge clk) begin : model
        logic nx;
        nx = exp_next_f();
        if (!rst_n) begin
            model_q.delete();
            m_pending = 0;
            m_starve  = 16'd0;
            m_cnt     = 32'd0;
        end else begin
            if (rd_ready && model_q.size() == 0 && m_starve != 16'hFFFF) m_starve = m_starve + 16'd1;
            if (gen_write) begin
                model_q.delete();
                m_pending = 0;
                m_cnt     = 32'd0;
            end else begin
                if (rd_ready && model_q.size() != 0) void'(model_q.pop_front());
                if (m_pending != 0) model_q.push_back(m_pend_word);
                m_pending = nx ? 1 : 0;
                if (nx) begin
                    m_cnt       = m_cnt + 32'd1;
                    m_pend_word = seed_base + m_cnt;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("next_o", {31'd0, next_o}, {31'd0, exp_next_f()});
            check("level", {27'd0, level}, model_q.size());
            check("rd_valid", {31'd0, rd_valid}, {31'd0, model_q.size() != 0});
            check("starve", {16'd0, starve}, {16'd0, m_starve});
            if (model_q.size() != 0) check("rd_data", rd_data, exp_data(model_q[0], bound));
        end
    end

    initial begin
        logic [5:0] fill_pat;
        int pct;
        fill_pat  = 6'b001111;
        rst_n     = 1'b0;
        rd_ready  = 1'b0;
        gen_write = 1'b0;
        bound     = 16'd0;
        seed_base = 32'h1000_0000;
        rnd       = 32'd0;
        m_pending = 0;
        m_cnt     = 32'd0;
        m_starve  = 16'd0;
        tick(2);
        check_en = 1;
        check("reset level", {27'd0, level}, 32'd0);
        check("reset rd_valid", {31'd0, rd_valid}, 32'd0);
        check("reset starve", {16'd0, starve}, 32'd0);
        check("reset next_o", {31'd0, next_o}, 32'd0);

        // Fill with the consumer idle: four requests, then stop.
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            check("fill next_o", {31'd0, next_o}, {31'd0, fill_pat[i]});
            tick(1);
        end
        check("fill level", {27'd0, level}, 32'd4);
        check("fill head", rd_data, 32'h1000_0001);

        // Consumer ready from reset: two starved cycles, then gapless stream.
        rst_n    = 1'b0;
        rd_ready = 1'b1;
        tick(1);
        rst_n = 1'b1;
        tick(2);
        check("stream starve", {16'd0, starve}, 32'd2);
        check("stream word1", rd_data, 32'h1000_0001);
        for (int k = 2; k < 8; k++) begin
            tick(1);
            check("stream valid", {31'd0, rd_valid}, 32'd1);
            check("stream word", rd_data, 32'h1000_0000 + 32'(k));
        end
        check("stream starve hold", {16'd0, starve}, 32'd2);

        // Reseed while full.
        rd_ready = 1'b0;
        tick(6);
        check("full level", {27'd0, level}, 32'd4);
        gen_write = 1'b1;
        seed_base = 32'h2000_0000;
        #1;
        check("reseed next_o", {31'd0, next_o}, 32'd0);
        tick(1);
        check("reseed level", {27'd0, level}, 32'd0);
        gen_write = 1'b0;
        #1;
        check("resume next_o", {31'd0, next_o}, 32'd1);
        tick(2);
        check("reseed word", rd_data, 32'h2000_0001);

        // Reset while a word is in flight.
        rst_n     = 1'b0;
        seed_base = 32'h3000_0000;
        tick(1);
        check("midreset level", {27'd0, level}, 32'd0);
        rst_n = 1'b1;
        tick(2);
        check("post reset level", {27'd0, level}, 32'd1);
        check("post reset word", rd_data, 32'h3000_0001);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            pct       = ((i / 300) % 2 == 1) ? 90 : 25;
            rd_ready  = ($urandom_range(0, 99) < pct);
            gen_write = ($urandom_range(0, 99) < 3);
            if (gen_write) seed_base = $urandom;
            rst_n = ($urandom_range(0, 199) != 0);
            bound = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            tick(1);
        end

`ifdef PRNG_BUF_RANGE_EN
        rst_n     = 1'b0;
        rd_ready  = 1'b0;
        gen_write = 1'b0;
        bound     = 16'd0;
        tick(1);
        rst_n     = 1'b1;
        gen_write = 1'b1;
        seed_base = 32'h7FFF_FFFF;
        tick(1);
        gen_write = 1'b0;
        tick(2);
        bound = 16'd10;
        #1;
        check("range 0x80000000*10", rd_data, 32'd5);
        bound = 16'd0;
        #1;
        check("range bound0 raw", rd_data, 32'h8000_0000);
        gen_write = 1'b1;
        seed_base = 32'hFFFF_FFFE;
        tick(1);
        gen_write = 1'b0;
        tick(2);
        bound = 16'hFFFF;
        #1;
        check("range max", rd_data, 32'h0000_FFFE);
`endif

        // Starvation counter saturation under a held reseed.
        rst_n     = 1'b0;
        gen_write = 1'b0;
        rd_ready  = 1'b0;
        bound     = 16'd0;
        tick(1);
        rst_n     = 1'b1;
        gen_write = 1'b1;
        rd_ready  = 1'b1;
        tick(65534);
        check("starve 0xFFFE", {16'd0, starve}, 32'h0000_FFFE);
        tick(1);
        check("starve sat", {16'd0, starve}, 32'h0000_FFFF);
        tick(4465);
        check("starve sat hold", {16'd0, starve}, 32'h0000_FFFF);

        check_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
